// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared definitions for the WS2812 frame sequencer.
// Holds the frame FSM state encoding, the pixel word width and the
// default bit-slot / latch-gap timings used as parameter defaults.
package ws2812_pkg;

  localparam int BITS_PER_PIXEL = 24;

  // Default timings in clock cycles.
  localparam int DEF_T0H    = 4;
  localparam int DEF_T1H    = 8;
  localparam int DEF_TBIT   = 12;
  localparam int DEF_TLATCH = 600;

  // Fixed encodings keep the state register layout stable for older tools.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_LATCH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/ws2812_bit_tx.sv
// ws2812_bit_tx: encodes one bit per TBIT-cycle slot on a registered dout.
// A 1 bit is high for T1H cycles, a 0 bit for T0H cycles, low for the rest.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   bit_valid   a bit is offered this cycle
//   bit_value   value of the offered bit
//   bit_ready   high while idle and in the last cycle of a slot
//   dout        WS2812 data line (registered)
module ws2812_bit_tx
  import ws2812_pkg::*;
#(
  parameter int T0H  = DEF_T0H,
  parameter int T1H  = DEF_T1H,
  parameter int TBIT = DEF_TBIT
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_valid,
  input  logic bit_value,
  output logic bit_ready,
  output logic dout
);

  localparam int CW = (TBIT > 1) ? $clog2(TBIT) : 1;

  logic          active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          val_q, val_d;
  logic          dout_q, dout_d;
  logic          slot_last;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] high_len;

  always_comb begin
    slot_last = active_q && (cnt_q == CW'(TBIT - 1));
    bit_ready = !active_q || slot_last;
    cnt_inc   = cnt_q + CW'(1);
    high_len  = val_q ? CW'(T1H) : CW'(T0H);

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    active_d = active_q;
    cnt_d    = cnt_q;
    val_d    = val_q;
    dout_d   = dout_q;

    if (bit_valid && bit_ready) begin
      // New slot always starts high because T0H > 0.
      active_d = 1'b1;
      cnt_d    = '0;
      val_d    = bit_value;
      dout_d   = 1'b1;
    end else if (slot_last) begin
      active_d = 1'b0;
      cnt_d    = '0;
      dout_d   = 1'b0;
    end else if (active_q) begin
      cnt_d  = cnt_inc;
      dout_d = (cnt_inc < high_len);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs.
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      val_q    <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      val_q    <= val_d;
      dout_q   <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl: sends one frame of NUM_LEDS GRB pixels to a WS2812 chain.
// Fetches pixels over a pix_rd/pix_valid handshake (prefetching the next
// pixel while the current one shifts out), serializes them MSB first via
// ws2812_bit_tx, then holds the line low for the latch gap.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        one-cycle frame request, ignored while busy
//   pix_rd       one-cycle pixel request, pix_addr = requested index
//   pix_valid    pixel strobe, pix_data = {G, R, B}
//   dout         WS2812 data line
//   busy         frame in progress
//   frame_done   one-cycle pulse after the latch gap
//   underrun     one-cycle pulse when the next pixel was not there in time
module ws2812_frame_ctrl
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int TBIT     = DEF_TBIT,
  parameter int TLATCH   = DEF_TLATCH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        pix_rd,
  output logic [7:0]  pix_addr,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        dout,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam int         LW       = (TLATCH > 1) ? $clog2(TLATCH) : 1;
  localparam logic [7:0] LAST_IDX = 8'(NUM_LEDS - 1);

  state_e                     state_q, state_d;
  logic [BITS_PER_PIXEL-1:0]  shift_q, shift_d;
  logic [BITS_PER_PIXEL-1:0]  hold_q, hold_d;
  logic                       hold_vld_q, hold_vld_d;
  logic [4:0]                 bit_idx_q, bit_idx_d;
  logic [7:0]                 pix_idx_q, pix_idx_d;
  logic [7:0]                 pix_addr_q, pix_addr_d;
  logic                       pix_rd_q, pix_rd_d;
  logic                       pend_q, pend_d;
  logic [LW-1:0]              latch_cnt_q, latch_cnt_d;

  logic bit_valid, bit_value, bit_ready;
  logic req_open, accept, last_pix, pixel_end, underrun_c;

  ws2812_bit_tx #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT)
  ) u_bit_tx (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (bit_valid),
    .bit_value (bit_value),
    .bit_ready (bit_ready),
    .dout      (dout)
  );

  always_comb begin
    // A request is open from its pix_rd cycle until the first pix_valid.
    req_open   = pix_rd_q || pend_q;
    accept     = req_open && pix_valid;
    last_pix   = (pix_idx_q == LAST_IDX);
    // Last cycle of bit 0 of the current pixel.
    pixel_end  = (state_q == ST_SEND) && bit_ready && (bit_idx_q == 5'd0);
    // Data arriving in that very cycle is too late: the hold register
    // must already be full.
    underrun_c = pixel_end && !last_pix && !hold_vld_q;

    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    bit_idx_d   = bit_idx_q;
    pix_idx_d   = pix_idx_q;
    pix_addr_d  = pix_addr_q;
    pix_rd_d    = 1'b0;
    pend_d      = req_open && !pix_valid;
    latch_cnt_d = latch_cnt_q;
    bit_valid   = 1'b0;
    bit_value   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_FETCH;
          pix_rd_d   = 1'b1;
          pix_addr_d = 8'd0;
          pix_idx_d  = 8'd0;
          hold_vld_d = 1'b0;
        end
      end

      ST_FETCH: begin
        if (accept) begin
          // Bit 23 starts on the next edge; prefetch pixel 1 at the same time.
          bit_valid = 1'b1;
          bit_value = pix_data[BITS_PER_PIXEL-1];
          shift_d   = pix_data;
          bit_idx_d = 5'd23;
          state_d   = ST_SEND;
          if (!last_pix) begin
            pix_rd_d   = 1'b1;
            pix_addr_d = 8'd1;
          end
        end
      end

      ST_SEND: begin
        if (accept && !underrun_c) begin
          hold_d     = pix_data;
          hold_vld_d = 1'b1;
        end
        if (bit_ready) begin
          if (bit_idx_q != 5'd0) begin
            bit_valid = 1'b1;
            bit_value = shift_q[bit_idx_q - 5'd1];
            bit_idx_d = bit_idx_q - 5'd1;
          end else if (last_pix) begin
            state_d     = ST_LATCH;
            latch_cnt_d = '0;
          end else if (hold_vld_q) begin
            bit_valid  = 1'b1;
            bit_value  = hold_q[BITS_PER_PIXEL-1];
            shift_d    = hold_q;
            hold_vld_d = 1'b0;
            bit_idx_d  = 5'd23;
            pix_idx_d  = pix_idx_q + 8'd1;
            if ((pix_idx_q + 8'd1) != LAST_IDX) begin
              pix_rd_d   = 1'b1;
              pix_addr_d = pix_idx_q + 8'd2;
            end
          end else begin
            // Underrun: abandon the frame and forget the late request.
            state_d     = ST_LATCH;
            latch_cnt_d = '0;
            pend_d      = 1'b0;
          end
        end
      end

      ST_LATCH: begin
        pend_d = 1'b0;
        if (latch_cnt_q == LW'(TLATCH - 1)) begin
          state_d = ST_DONE;
        end else begin
          latch_cnt_d = latch_cnt_q + LW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      bit_idx_q   <= '0;
      pix_idx_q   <= '0;
      pix_addr_q  <= '0;
      pix_rd_q    <= 1'b0;
      pend_q      <= 1'b0;
      latch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      bit_idx_q   <= bit_idx_d;
      pix_idx_q   <= pix_idx_d;
      pix_addr_q  <= pix_addr_d;
      pix_rd_q    <= pix_rd_d;
      pend_q      <= pend_d;
      latch_cnt_q <= latch_cnt_d;
    end
  end

  assign pix_rd     = pix_rd_q;
  assign pix_addr   = pix_addr_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);
  assign underrun   = underrun_c;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Testbench for ws2812_frame_ctrl. Expected dout pulses, pixel requests,
// underrun, frame_done and busy-fall events are computed from the frame
// timing rules with plain arithmetic when a frame is launched and queued;
// monitors pop and compare as the DUT produces each event. A second
// single-LED instance is fed all-ones pixels.
module tb_ws2812_frame_ctrl;

  localparam int T0H    = 4;
  localparam int T1H    = 8;
  localparam int TBIT   = 12;
  localparam int TLATCH = 600;
  localparam int PIX_SLOTS = 24 * TBIT;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst, start, start1;
  logic        pix_rd, pix_valid, dout, busy, frame_done, underrun;
  logic [7:0]  pix_addr;
  logic [23:0] pix_data;
  logic        pix_rd1, pix_valid1, dout1, busy1, done1, under1;
  logic [7:0]  pix_addr1;
  logic [23:0] pix_data1;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  ev_t exp_pulse[$];
  ev_t exp_rd[$];
  ev_t exp_done[$];
  ev_t exp_under[$];
  ev_t exp_bfall[$];

  bit          mon_en = 1'b1;
  logic [23:0] pixmem [2];
  int          lat_tab [2];
  bit          dup_en = 1'b0;
  int          inject_cyc = -1;
  int          s1_base = 0;
  int          n1_idx = 0, n1_rd = 0, n1_done = 0;

  ws2812_frame_ctrl #(
    .NUM_LEDS (2), .T0H (T0H), .T1H (T1H), .TBIT (TBIT), .TLATCH (TLATCH)
  ) u_dut (
    .clk (clk), .rst (rst), .start (start),
    .pix_rd (pix_rd), .pix_addr (pix_addr),
    .pix_valid (pix_valid), .pix_data (pix_data),
    .dout (dout), .busy (busy), .frame_done (frame_done), .underrun (underrun)
  );

  ws2812_frame_ctrl #(
    .NUM_LEDS (1), .T0H (T0H), .T1H (T1H), .TBIT (TBIT), .TLATCH (TLATCH)
  ) u_one (
    .clk (clk), .rst (rst), .start (start1),
    .pix_rd (pix_rd1), .pix_addr (pix_addr1),
    .pix_valid (pix_valid1), .pix_data (pix_data1),
    .dout (dout1), .busy (busy1), .frame_done (done1), .underrun (under1)
  );

  // Single-LED source answers in the same cycle as the request.
  assign pix_valid1 = pix_rd1;
  assign pix_data1  = 24'hFFFFFF;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk(input int c, input int v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    return e;
  endfunction

  // Pixel source: answers each request after lat_tab[addr] cycles
  // (negative = never); optional duplicate strobe after pixel 1 and a
  // stray strobe at inject_cyc.
  initial begin : source
    bit   pend = 1'b0, dup = 1'b0;
    int   cnt = 0;
    logic [7:0] addr = '0;
    pix_valid = 1'b0;
    pix_data  = '0;
    forever begin
      @(negedge clk);
      pix_valid = 1'b0;
      if (pix_rd && lat_tab[pix_addr[0]] >= 0) begin
        pend = 1'b1;
        addr = pix_addr;
        cnt  = lat_tab[pix_addr[0]];
      end
      if (dup) begin
        pix_valid = 1'b1;
        pix_data  = ~pixmem[1];
        dup       = 1'b0;
      end else if (pend) begin
        if (cnt == 0) begin
          pix_valid = 1'b1;
          pix_data  = pixmem[addr[0]];
          pend      = 1'b0;
          dup       = dup_en && (addr == 8'd1);
        end else begin
          cnt--;
        end
      end
      if (cyc == inject_cyc) begin
        pix_valid = 1'b1;
        pix_data  = 24'h5A5A5A;
      end
    end
  end

  // Main-DUT monitor.
  initial begin : monitor
    bit  dout_prev = 1'b0, busy_prev = 1'b0;
    int  rise_cyc = 0, hi_len = 0;
    ev_t e;
    forever begin
      @(negedge clk);
      if (dout && !dout_prev) begin
        rise_cyc = cyc;
        hi_len   = 1;
      end else if (dout) begin
        hi_len++;
      end else if (dout_prev && mon_en) begin
        if (exp_pulse.size() == 0) check("unexpected_pulse", rise_cyc, -1);
        else begin
          e = exp_pulse.pop_front();
          check("pulse_rise", rise_cyc, e.cyc);
          check("pulse_width", hi_len, e.val);
        end
      end
      dout_prev = dout;
      if (pix_rd && mon_en) begin
        if (exp_rd.size() == 0) check("unexpected_rd", cyc, -1);
        else begin
          e = exp_rd.pop_front();
          check("rd_cycle", cyc, e.cyc);
          check("rd_addr", pix_addr, e.val);
        end
      end
      if (underrun && mon_en) begin
        if (exp_under.size() == 0) check("unexpected_underrun", cyc, -1);
        else begin
          e = exp_under.pop_front();
          check("underrun_cycle", cyc, e.cyc);
        end
      end
      if (frame_done && mon_en) begin
        if (exp_done.size() == 0) check("unexpected_done", cyc, -1);
        else begin
          e = exp_done.pop_front();
          check("done_cycle", cyc, e.cyc);
        end
      end
      if (busy_prev && !busy && mon_en) begin
        if (exp_bfall.size() == 0) check("unexpected_busy_fall", cyc, -1);
        else begin
          e = exp_bfall.pop_front();
          check("busy_fall_cycle", cyc, e.cyc);
        end
      end
      busy_prev = busy;
    end
  end

  // Single-LED monitor: 24 one-bits, each 8 high, spaced TBIT apart.
  initial begin : monitor_one
    bit d1_prev = 1'b0;
    int r1_len = 0;
    forever begin
      @(negedge clk);
      if (dout1 && !d1_prev) begin
        check("one_rise", cyc, s1_base + TBIT * n1_idx);
        r1_len = 1;
      end else if (dout1) begin
        r1_len++;
      end else if (d1_prev) begin
        check("one_width", r1_len, T1H);
        n1_idx++;
      end
      d1_prev = dout1;
      if (done1) begin
        n1_done++;
        check("one_done_cycle", cyc, s1_base + PIX_SLOTS + TLATCH);
        check("one_bits", n1_idx, 24);
      end
      if (pix_rd1) begin
        n1_rd++;
        check("one_addr", pix_addr1, 0);
      end
    end
  end

  // Launch one frame on the main DUT and queue its expected events.
  // l1 < 0 withholds pixel 1; l1 > PIX_SLOTS-2 arrives too late.
  task automatic run_frame(input logic [23:0] p0, input logic [23:0] p1,
                           input int l0, input int l1, input bit dup,
                           input bit extra_starts, input bit with_one);
    int c0, s, n_sent, bits_end, done;
    bit under;
    logic [23:0] w;
    pixmem[0] = p0;
    pixmem[1] = p1;
    lat_tab[0] = l0;
    lat_tab[1] = l1;
    dup_en = dup;
    under = (l1 < 0) || (l1 > PIX_SLOTS - 2);
    @(posedge clk); #1;
    start = 1'b1;
    c0 = cyc;
    if (with_one) begin
      start1  = 1'b1;
      s1_base = c0 + 2;
      n1_idx  = 0;
    end
    s        = c0 + 2 + l0;
    n_sent   = under ? 1 : 2;
    bits_end = s + n_sent * PIX_SLOTS;
    done     = bits_end + TLATCH;
    exp_rd.push_back(mk(c0 + 1, 0));
    exp_rd.push_back(mk(s, 1));
    for (int p = 0; p < n_sent; p++) begin
      w = (p == 0) ? p0 : p1;
      for (int b = 0; b < 24; b++)
        exp_pulse.push_back(mk(s + (p * 24 + b) * TBIT, w[23 - b] ? T1H : T0H));
    end
    if (under) exp_under.push_back(mk(bits_end - 1, 0));
    if (l1 < 0) inject_cyc = bits_end + 100;
    exp_done.push_back(mk(done, 0));
    exp_bfall.push_back(mk(done + 1, 0));
    @(posedge clk); #1;
    start  = 1'b0;
    start1 = 1'b0;
    while (cyc < done + 3) begin
      start = extra_starts && (cyc == s + 100 || cyc == bits_end + 50 || cyc == done);
      @(posedge clk); #1;
    end
    start = 1'b0;
    inject_cyc = -1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : driver
    int c0;
    rst = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    lat_tab[0] = 0;
    lat_tab[1] = 0;
    pixmem[0] = '0;
    pixmem[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_dout", dout, 0);
    check("reset_busy", busy, 0);
    check("reset_pix_rd", pix_rd, 0);
    check("reset_pix_addr", pix_addr, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_underrun", underrun, 0);

    // Stray strobe in IDLE must leave the DUT idle.
    inject_cyc = cyc + 2;
    repeat (5) @(posedge clk);
    #1;
    inject_cyc = -1;
    check("idle_after_stray_busy", busy, 0);

    // Reference frame, alongside the single-LED instance.
    run_frame(24'h000FF0, 24'hA5A5A5, 0, 0, 1'b0, 1'b0, 1'b1);

    // Randomized frames, including the last in-time prefetch answer.
    for (int i = 0; i < 4; i++)
      run_frame($urandom, $urandom, $urandom_range(20, 0),
                (i == 3) ? PIX_SLOTS - 2 : $urandom_range(PIX_SLOTS - 2, 0),
                1'b1, 1'b0, 1'b0);

    // start pulses in SEND, LATCH and DONE have no effect.
    run_frame($urandom, $urandom, 3, 40, 1'b0, 1'b1, 1'b0);

    // Underrun: answer one cycle too late, then never answer.
    run_frame($urandom, $urandom, 1, PIX_SLOTS - 1, 1'b0, 1'b0, 1'b0);
    run_frame($urandom, $urandom, 2, -1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of pixel 1.
    mon_en = 1'b0;
    pixmem[0] = $urandom;
    pixmem[1] = $urandom;
    lat_tab[0] = 2;
    lat_tab[1] = 4;
    dup_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < c0 + 4 + PIX_SLOTS + 30) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_dout", dout, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pix_rd", pix_rd, 0);
    check("midrst_pix_addr", pix_addr, 0);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_underrun", underrun, 0);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Clean frame after reset.
    run_frame($urandom, $urandom, 5, 100, 1'b0, 1'b0, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    check("leftover_pulses", exp_pulse.size(), 0);
    check("leftover_rd", exp_rd.size(), 0);
    check("leftover_done", exp_done.size(), 0);
    check("leftover_underrun", exp_under.size(), 0);
    check("leftover_busy_fall", exp_bfall.size(), 0);
    check("one_rd_count", n1_rd, 1);
    check("one_done_count", n1_done, 1);
    check("one_pulse_count", n1_idx, 24);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
